// File: rtl/ifft_result_fetcher.sv
// Fetches one frame of result bins and streams them in order into the IFFT load port.
// Latency: first ifft_xn_valid at START+1+L+1 cycles (L = read latency); one word per cycle when L <= FIFO_DEPTH-1.
// Backpressure: ifft_xn_ready=0 holds the head word; reads stop once outstanding + buffered reaches FIFO_DEPTH.
//
// Ports:
//   clk, rst_n              clock / async active-low reset
//   proc_done               main FSM done level; a rising edge arms one frame
//   result_address/_read_enable, result_data/_read_valid   in-order read handshake
//   ifft_start, ifft_xn_re/_im/_index/_valid/_ready         IFFT load stream
//   frame_done, busy        frame status
// Optional build macro: RESULT_DC_BLOCK_EN zeroes the DC (bin 0) and Nyquist (bin N_BINS/2) words.
// FIFO_DEPTH is assumed to be a power of two so the FIFO pointers wrap naturally.
module ifft_result_fetcher #(
   parameter int N_BINS     = 512,
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 36,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     proc_done,
   output logic [ADDR_W-1:0]        result_address,
   output logic                     result_read_enable,
   input  logic [DATA_W-1:0]        result_data,
   input  logic                     result_read_valid,
   output logic                     ifft_start,
   output logic signed [17:0]       ifft_xn_re,
   output logic signed [17:0]       ifft_xn_im,
   output logic [ADDR_W-1:0]        ifft_xn_index,
   output logic                     ifft_xn_valid,
   input  logic                     ifft_xn_ready,
   output logic                     frame_done,
   output logic                     busy
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PART_W = 18;

   localparam logic [ADDR_W:0]   BINS_C  = (ADDR_W + 1)'(N_BINS);
   localparam logic [ADDR_W:0]   LAST_C  = (ADDR_W + 1)'(N_BINS - 1);
   localparam logic [CNT_W:0]    DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_FETCH,
      ST_DRAIN
   } state_t;

   state_t              state_q;
   logic                done_prev_q;
   logic                ifft_start_q;
   logic                frame_done_q;
   logic                busy_q;

   logic [ADDR_W:0]     req_cnt_q, req_cnt_d;
   logic [ADDR_W:0]     acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0]    outst_q, outst_d;
   logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

   logic                rd_en;
   logic                rsp_ok;
   logic                push;
   logic                pop;
   logic [CNT_W:0]      credit_used;
   logic [DATA_W-1:0]   head;
   logic                word_zero;

   // Credits count both words still in flight and words already buffered,
   // so a returned word always finds a free FIFO slot.
   assign credit_used = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
   assign rd_en       = (state_q == ST_FETCH) && (req_cnt_q < BINS_C) && (credit_used < DEPTH_W);

   // A response with nothing outstanding is a protocol error and is dropped.
   assign rsp_ok = result_read_valid && (outst_q != '0);
   assign ifft_xn_valid = (fifo_cnt_q != '0);
   assign pop    = ifft_xn_valid && ifft_xn_ready;
   assign push   = rsp_ok && ((fifo_cnt_q != DEPTH_C) || pop);

   always_comb begin
      req_cnt_d = req_cnt_q;
      acc_cnt_d = acc_cnt_q;
      if (state_q == ST_START) begin
         req_cnt_d = '0;
         acc_cnt_d = '0;
      end else begin
         if (rd_en) req_cnt_d = req_cnt_q + 1'b1;
         if (pop)   acc_cnt_d = acc_cnt_q + 1'b1;
      end

      outst_d = outst_q;
      if (rd_en && !rsp_ok)
         outst_d = outst_q + 1'b1;
      else if (!rd_en && rsp_ok)
         outst_d = outst_q - 1'b1;

      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop)
         fifo_cnt_d = fifo_cnt_q + 1'b1;
      else if (!push && pop)
         fifo_cnt_d = fifo_cnt_q - 1'b1;
   end

   // Frame control. done_prev_q resets high so a done level already present
   // at reset release is not mistaken for a new rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         done_prev_q  <= 1'b1;
         ifft_start_q <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         done_prev_q  <= proc_done;
         ifft_start_q <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (proc_done && !done_prev_q) begin
                  state_q      <= ST_START;
                  ifft_start_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            ST_START: state_q <= ST_FETCH;
            ST_FETCH: begin
               if (rd_en && (req_cnt_q == LAST_C)) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Completion keys off the accept of the last bin so frame_done
               // lands exactly one cycle after it.
               if (pop && (acc_cnt_q == LAST_C)) begin
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt_q  <= '0;
         acc_cnt_q  <= '0;
         outst_q    <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         req_cnt_q  <= req_cnt_d;
         acc_cnt_q  <= acc_cnt_d;
         outst_q    <= outst_d;
         fifo_cnt_q <= fifo_cnt_d;
         if (push) begin
            mem_q[wr_ptr_q] <= result_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign head = mem_q[rd_ptr_q];

`ifdef RESULT_DC_BLOCK_EN
   // Words leave strictly in bin order, so the accept counter names the head bin.
   assign word_zero = (acc_cnt_q[ADDR_W-1:0] == '0) ||
                      (acc_cnt_q[ADDR_W-1:0] == ADDR_W'(N_BINS / 2));
`else
   assign word_zero = 1'b0;
`endif

   // Gated by valid so an empty buffer presents zeros rather than stale data.
   assign ifft_xn_re = (ifft_xn_valid && !word_zero) ? head[2*PART_W-1:PART_W] : '0;
   assign ifft_xn_im = (ifft_xn_valid && !word_zero) ? head[PART_W-1:0] : '0;

   assign result_address     = req_cnt_q[ADDR_W-1:0];
   assign result_read_enable = rd_en;
   assign ifft_xn_index      = acc_cnt_q[ADDR_W-1:0];
   assign ifft_start         = ifft_start_q;
   assign frame_done         = frame_done_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_ifft_result_fetcher.sv
// Directed bench for ifft_result_fetcher: reset, latency/throughput, backpressure,
// ignored re-arm, mid-frame reset and DC/Nyquist handling.
// A behavioural responder returns bin k as {re=k, im=-k} after a programmable latency.
module tb_ifft_result_fetcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        proc_done;
   logic [8:0]  result_address;
   logic        result_read_enable;
   logic [35:0] result_data;
   logic        result_read_valid;
   logic        ifft_start;
   logic [17:0] ifft_xn_re;
   logic [17:0] ifft_xn_im;
   logic [8:0]  ifft_xn_index;
   logic        ifft_xn_valid;
   logic        ifft_xn_ready;
   logic        frame_done;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Bench controls, written only by the main sequence.
   int lat = 2;
   int ready_mode = 0;
   bit dc_pat = 1'b0;
   int clr_gen = 0;

   // Monitor results, written only by the monitor.
   int seen_gen = 0;
   int reqs = 0, accs = 0, start_cnt = 0, fd_cnt = 0;
   int addr_err = 0, idx_err = 0, dat_err = 0, credit_err = 0, stab_err = 0;
   int start_cyc = 0, fd_cyc = 0, last_acc = 0, first_vld = -1;
   logic [17:0] cap_re [512];
   logic [17:0] cap_im [512];

   ifft_result_fetcher dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .proc_done          (proc_done),
      .result_address     (result_address),
      .result_read_enable (result_read_enable),
      .result_data        (result_data),
      .result_read_valid  (result_read_valid),
      .ifft_start         (ifft_start),
      .ifft_xn_re         (ifft_xn_re),
      .ifft_xn_im         (ifft_xn_im),
      .ifft_xn_index      (ifft_xn_index),
      .ifft_xn_valid      (ifft_xn_valid),
      .ifft_xn_ready      (ifft_xn_ready),
      .frame_done         (frame_done),
      .busy               (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [35:0] resp_data(input logic [8:0] a);
      logic [17:0] re;
      logic [17:0] im;
      re = 18'(a);
      im = -re;
      if (dc_pat && (a == 9'd0 || a == 9'd256)) return {18'h3FFFF, 18'h3FFFF};
      return {re, im};
   endfunction

   // Responder: request seen in cycle t returns in cycle t+lat.
   initial begin
      bit          pv [8];
      logic [8:0]  pa [8];
      bit          cap_en;
      logic [8:0]  cap_addr;
      result_read_valid = 1'b0;
      result_data = '0;
      for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pa[i] = '0; end
      forever begin
         @(negedge clk);
         cap_en   = rst_n && result_read_enable;
         cap_addr = result_address;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            for (int i = 0; i < 8; i++) pv[i] = 1'b0;
            result_read_valid = 1'b0;
            result_data = '0;
         end else begin
            for (int i = 7; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
            pv[0] = cap_en;
            pa[0] = cap_addr;
            result_read_valid = pv[lat-1];
            result_data = pv[lat-1] ? resp_data(pa[lat-1]) : '0;
         end
      end
   end

   // Ready driver: mode 0 tied high, mode 1 one cycle on / two off.
   initial begin
      int ph;
      ph = 0;
      ifft_xn_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ph = (ph == 2) ? 0 : ph + 1;
         ifft_xn_ready = (ready_mode == 0) ? 1'b1 : (ph == 0);
      end
   end

   // Monitor: sampled on the falling edge, away from the active edge.
   initial begin
      bit          hold_prev;
      logic [17:0] p_re, p_im;
      logic [8:0]  p_idx;
      logic [17:0] er, ei;
      int          k;
      hold_prev = 1'b0;
      p_re = '0; p_im = '0; p_idx = '0;
      forever begin
         @(negedge clk);
         if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            reqs = 0; accs = 0; start_cnt = 0; fd_cnt = 0;
            addr_err = 0; idx_err = 0; dat_err = 0; credit_err = 0; stab_err = 0;
            start_cyc = 0; fd_cyc = 0; last_acc = 0; first_vld = -1;
         end
         if (!rst_n) begin
            hold_prev = 1'b0;
         end else begin
            if (ifft_start) begin start_cnt++; start_cyc = cyc; end
            if (result_read_enable) begin
               if (reqs - accs >= 4) credit_err++;
               if (result_address !== 9'(reqs)) addr_err++;
               reqs++;
            end
            if (hold_prev && (ifft_xn_valid !== 1'b1 || ifft_xn_re !== p_re ||
                              ifft_xn_im !== p_im || ifft_xn_index !== p_idx))
               stab_err++;
            if (ifft_xn_valid && first_vld < 0) first_vld = cyc;
            if (ifft_xn_valid && ifft_xn_ready) begin
               k = accs % 512;
               er = 18'(k);
               ei = -er;
               if (dc_pat && (k == 0 || k == 256)) begin er = 18'h3FFFF; ei = 18'h3FFFF; end
`ifdef RESULT_DC_BLOCK_EN
               if (k == 0 || k == 256) begin er = '0; ei = '0; end
`endif
               if (ifft_xn_index !== 9'(k)) idx_err++;
               if (ifft_xn_re !== er || ifft_xn_im !== ei) dat_err++;
               cap_re[k] = ifft_xn_re;
               cap_im[k] = ifft_xn_im;
               accs++;
               last_acc = cyc;
            end
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            hold_prev = ifft_xn_valid && !ifft_xn_ready;
            p_re = ifft_xn_re; p_im = ifft_xn_im; p_idx = ifft_xn_index;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      clr_gen++;
      proc_done = 1'b0;
      step(2);
      proc_done = 1'b1;
      step(2);
   endtask

   task automatic wait_fd(input int budget);
      int b;
      b = budget;
      while (fd_cnt == 0 && b > 0) begin @(posedge clk); b--; end
      #1;
      check("frame_done_seen", 64'(fd_cnt > 0), 64'd1);
      step(5);
   endtask

   task automatic wait_acc(input int n, input int budget);
      int b;
      b = budget;
      while (accs < n && b > 0) begin @(posedge clk); b--; end
      #1;
      check("accept_reached", 64'(accs >= n), 64'd1);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({result_read_enable, result_address, ifft_start, ifft_xn_re, ifft_xn_im,
                  ifft_xn_index, ifft_xn_valid, frame_done, busy});
   endfunction

   initial begin
      rst_n = 1'b1;
      proc_done = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      check("reset_outputs", all_outs(), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Done already high at release: nothing may start.
      step(20);
      check("idle_start_cnt", 64'(start_cnt), 64'd0);
      check("idle_reads", 64'(reqs), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      // Frame 1: latency 2, ready high.
      lat = 2; ready_mode = 0;
      start_frame();
      check("f1_start_once", 64'(start_cnt), 64'd1);
      check("f1_busy", 64'(busy), 64'd1);
      wait_fd(3000);
      check("f1_accepts", 64'(accs), 64'd512);
      check("f1_reqs", 64'(reqs), 64'd512);
      check("f1_addr_err", 64'(addr_err), 64'd0);
      check("f1_index_err", 64'(idx_err), 64'd0);
      check("f1_data_err", 64'(dat_err), 64'd0);
      check("f1_fd_count", 64'(fd_cnt), 64'd1);
      check("f1_fd_after_last", 64'(fd_cyc - last_acc), 64'd1);
      check("f1_first_valid_lat", 64'(first_vld - start_cyc), 64'd4);
      check("f1_one_per_cycle", 64'(last_acc - first_vld), 64'd511);
      check("f1_busy_low", 64'(busy), 64'd0);

      // Frame 2: latency 3, ready 1-on/2-off.
      lat = 3; ready_mode = 1;
      start_frame();
      wait_fd(6000);
      ready_mode = 0;
      check("f2_accepts", 64'(accs), 64'd512);
      check("f2_credit_err", 64'(credit_err), 64'd0);
      check("f2_stable_err", 64'(stab_err), 64'd0);
      check("f2_index_err", 64'(idx_err), 64'd0);
      check("f2_data_err", 64'(dat_err), 64'd0);
      check("f2_fd_count", 64'(fd_cnt), 64'd1);
      check("f2_first_valid_lat", 64'(first_vld - start_cyc), 64'd5);

      // Frame 3: a second done edge mid-frame is ignored.
      lat = 2;
      start_frame();
      wait_acc(100, 600);
      proc_done = 1'b0;
      step(1);
      proc_done = 1'b1;
      step(1);
      wait_fd(3000);
      step(30);
      check("f3_fd_count", 64'(fd_cnt), 64'd1);
      check("f3_accepts", 64'(accs), 64'd512);
      check("f3_start_once", 64'(start_cnt), 64'd1);
      check("f3_index_err", 64'(idx_err), 64'd0);

      // Frame 4: reset mid-frame, then a clean frame from bin 0.
      start_frame();
      wait_acc(300, 1000);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_outputs", all_outs(), 64'd0);
      step(3);
      check("midrst_no_fd", 64'(fd_cnt), 64'd0);
      rst_n = 1'b1;
      step(5);
      start_frame();
      wait_fd(3000);
      check("f4_accepts", 64'(accs), 64'd512);
      check("f4_reqs", 64'(reqs), 64'd512);
      check("f4_index_err", 64'(idx_err), 64'd0);
      check("f4_data_err", 64'(dat_err), 64'd0);
      check("f4_fd_count", 64'(fd_cnt), 64'd1);

      // Frame 5: all-ones words at DC and Nyquist, latency 1.
      lat = 1; dc_pat = 1'b1;
      start_frame();
      wait_fd(3000);
`ifdef RESULT_DC_BLOCK_EN
      check("dc_re0", 64'(cap_re[0]), 64'd0);
      check("dc_im0", 64'(cap_im[0]), 64'd0);
      check("dc_re256", 64'(cap_re[256]), 64'd0);
      check("dc_im256", 64'(cap_im[256]), 64'd0);
`else
      check("dc_re0", 64'(cap_re[0]), 64'h3FFFF);
      check("dc_im0", 64'(cap_im[0]), 64'h3FFFF);
      check("dc_re256", 64'(cap_re[256]), 64'h3FFFF);
      check("dc_im256", 64'(cap_im[256]), 64'h3FFFF);
`endif
      check("dc_re1", 64'(cap_re[1]), 64'h1);
      check("dc_im1", 64'(cap_im[1]), 64'h3FFFF);
      check("f5_data_err", 64'(dat_err), 64'd0);
      check("f5_one_per_cycle", 64'(last_acc - first_vld), 64'd511);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifft_result_fetcher.md
Name: ifft_result_fetcher

Overview:
- Reader side of the pitch-correction core's result interface.
- After the main FSM raises its done flag, the block walks result bins 0..N-1 over the result_address / result_read_enable / result_read_valid / result_data handshake.
- Each returned bin is split into real/imag, buffered in a small credit-controlled FIFO, and streamed in order into the IFFT load port with valid/ready flow control.
- One frame is fetched per rising edge of done.

Parameters:
- N_BINS, 512, bins per frame; power of two; sets address counter width.
- ADDR_W, 9, log2(N_BINS).
- DATA_W, 36, packed bin width: real in [35:18], imag in [17:0].
- FIFO_DEPTH, 4, return-buffer entries; also the maximum number of outstanding reads.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- proc_done  in  1  main FSM done level; a 0->1 transition arms a frame.
- result_address  out  ADDR_W  bin index being requested.
- result_read_enable  out  1  one-cycle read request for result_address.
- result_data  in  DATA_W  signed packed bin, qualified by result_read_valid.
- result_read_valid  in  1  returned data valid; responses arrive in request order, latency >=1 cycle.
- ifft_start  out  1  one-cycle pulse; frame load begins.
- ifft_xn_re  out  18  signed real part of current bin.
- ifft_xn_im  out  18  signed imag part of current bin.
- ifft_xn_index  out  ADDR_W  bin index of current output word.
- ifft_xn_valid  out  1  output word valid.
- ifft_xn_ready  in  1  IFFT accepts the word when valid && ready.
- frame_done  out  1  one-cycle pulse after bin N-1 is accepted.
- busy  out  1  high from arm until frame_done.

Behaviour:
- Reset (async assert, sync-release use): all outputs 0, state IDLE, counters 0, FIFO empty.
  - Previous-value register for proc_done resets to 1, so a high proc_done at reset release does not start a frame.
- States:
  - IDLE: on proc_done 0->1, go to START.
  - START: assert ifft_start for one cycle, set busy=1, clear counters, go to FETCH.
  - FETCH: issue reads. Go to DRAIN when the request counter has issued N_BINS requests.
  - DRAIN: wait until all N_BINS words are accepted downstream, then pulse frame_done, drop busy in the same cycle, go to IDLE.
- Request rule: result_read_enable=1 only when in FETCH, requests issued < N_BINS, and (outstanding + fifo_count) < FIFO_DEPTH.
  - result_address = request counter; counter increments on each request.
  - Back-to-back requests are allowed: one per cycle.
- Outstanding counter:
  - +1 per request, -1 per result_read_valid; both in the same cycle leaves it unchanged.
  - result_read_valid with outstanding=0 is a protocol error: data is dropped and the counter does not underflow.
- FIFO:
  - Pushes on result_read_valid; credits guarantee it never overflows.
  - Pops on ifft_xn_valid && ifft_xn_ready.
  - Simultaneous push and pop on a full or empty FIFO must be handled: count unchanged, data ordered correctly.
  - ifft_xn_valid = FIFO non-empty. Head word drives re/im combinationally from FIFO storage.
  - ifft_xn_index = accepted-word counter.
- Backpressure: while ifft_xn_ready=0, outputs hold stable and no requests are issued beyond available credit.
- proc_done edges while busy are ignored (not queued).
- Asserting rst_n mid-frame aborts immediately with no frame_done; all state is cleared.
- Throughput: with read latency L <= FIFO_DEPTH-1 and ifft_xn_ready tied high, one word per cycle.
  - First ifft_xn_valid at START+1+L+1 cycles.

Optional Feature:
- Macro: RESULT_DC_BLOCK_EN.
- Defined: words for bins 0 (DC) and N_BINS/2 (Nyquist) are emitted with re=im=0. Handshake, index, and timing are unchanged; the reads are still issued.
- Undefined: all bins pass through unmodified.

Test Plan:
- Reset with proc_done=1, then hold for 20 cycles -> no result_read_enable and no ifft_start. Then toggle proc_done 0->1 -> ifft_start pulses once and busy=1.
- Responder latency 2, bin k returns {re=k, im=-k}, ready=1 -> 512 words with index 0..511 in order, im=-index; frame_done once, exactly 1 cycle after the index-511 accept.
- Responder latency 3 and ready toggled 1-cycle-on/2-off -> outstanding+fifo_count never >4, no word lost or duplicated, outputs stable while ready=0.
- Second 0->1 proc_done edge at bin 100 of a frame -> ignored; exactly one frame_done and 512 accepts.
- rst_n pulsed low at bin 300 -> all outputs 0 asynchronously; no frame_done. The next proc_done edge fetches a full frame from bin 0.
- With RESULT_DC_BLOCK_EN, bins 0 and 256 return 36'h3FFFF_3FFFF -> ifft_xn_re=ifft_xn_im=0 at indices 0 and 256; index 1 passes through unchanged.
